// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the memory stage:
//   - MEMctrl bit positions (RD, WR, IO, WORD, LDSEL)
//   - bus sequencer state encoding
//   - mapper register window base address and a range-test helper
// -----------------------------------------------------------------------------
package cpu_pkg;

    // MEMctrl bit indices; bits [6:5] carry nothing for this stage.
    localparam int MC_RD    = 0;
    localparam int MC_WR    = 1;
    localparam int MC_IO    = 2;
    localparam int MC_WORD  = 3;
    localparam int MC_LDSEL = 4;

    // Mapper registers occupy the top four bytes of memory space.
    localparam logic [15:0] MAPPER_BASE = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACC_LO = 2'b01,
        ST_ACC_HI = 2'b10
    } mem_state_e;

    function automatic logic is_mapper(input logic [15:0] addr);
        return (addr >= MAPPER_BASE);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Byte-wide memory bus between the memory stage (master) and memory/IO
// (slave).
//   mem_addr  [15:0]  byte address          master -> slave
//   mem_wdata [7:0]   store data            master -> slave
//   mem_rd, mem_wr    access strobes        master -> slave
//   mem_io            IO space select       master -> slave
//   mem_rdata [7:0]   load data             slave  -> master
//   mem_ack           access complete       slave  -> master
//
// Handshake: a byte access is requested while mem_rd or mem_wr is high.
// The master holds address, data, strobes and mem_io stable until the slave
// raises mem_ack; the access completes on the rising edge that ends the
// cycle in which mem_ack is high, and mem_rdata is sampled in that same
// cycle. mem_ack outside a request is ignored.
// -----------------------------------------------------------------------------
interface mem_stage_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_io;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_rd,
        output mem_wr,
        output mem_io,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_rd,
        input  mem_wr,
        input  mem_io,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_bus_fsm.sv
// -----------------------------------------------------------------------------
// mem_bus_fsm
// Sequences one memory instruction into one or two byte accesses on the
// memory bus. All bus outputs are registered and change only on state
// transitions, so they hold while the slave withholds mem_ack.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   mem_op_i           instruction in the EXE latch is a memory op
//   rd_i, wr_i         effective read / write (read wins when both set)
//   io_i, word_i       IO space, 16-bit access request
//   addr_lo_i          first byte address
//   addr_hi_i          second byte address (addr_lo_i + 1, wrapping)
//   wdata_i            16-bit store data
//   bus                memory bus, master side
//   final_ack_o        last byte of the instruction completes this cycle
//   load_data_o        assembled load data, valid with final_ack_o
//   state_o            current sequencer state
// -----------------------------------------------------------------------------
module mem_bus_fsm
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_op_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic        io_i,
    input  logic        word_i,
    input  logic [15:0] addr_lo_i,
    input  logic [15:0] addr_hi_i,
    input  logic [15:0] wdata_i,
    mem_stage_if.master bus,
    output logic        final_ack_o,
    output logic [15:0] load_data_o,
    output mem_state_e  state_o
);

    mem_state_e  state_q;
    logic        rd_q;
    logic        wr_q;
    logic        io_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  lo_byte_q;
    logic        two_byte;

    // IO space is byte-wide: WORD is honoured for memory space only.
    assign two_byte = word_i & ~io_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            io_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            lo_byte_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_op_i) begin
                        state_q <= ST_ACC_LO;
                        rd_q    <= rd_i;
                        wr_q    <= wr_i;
                        io_q    <= io_i;
                        addr_q  <= addr_lo_i;
                        wdata_q <= wdata_i[7:0];
                    end
                end
                ST_ACC_LO: begin
                    if (bus.mem_ack) begin
                        lo_byte_q <= bus.mem_rdata;
                        if (two_byte) begin
                            state_q <= ST_ACC_HI;
                            addr_q  <= addr_hi_i;
                            wdata_q <= wdata_i[15:8];
                        end else begin
                            state_q <= ST_IDLE;
                            rd_q    <= 1'b0;
                            wr_q    <= 1'b0;
                            io_q    <= 1'b0;
                        end
                    end
                end
                ST_ACC_HI: begin
                    if (bus.mem_ack) begin
                        state_q <= ST_IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        io_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    io_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_rd    = rd_q;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_io    = io_q;

    assign final_ack_o = bus.mem_ack &
                         (((state_q == ST_ACC_LO) & ~two_byte) |
                          (state_q == ST_ACC_HI));

    // The final byte arrives in the same cycle the WB latch loads, so it is
    // taken straight from the bus; only the low byte of a word is buffered.
    assign load_data_o = (state_q == ST_ACC_HI) ? {bus.mem_rdata, lo_byte_q}
                                                : {8'h00, bus.mem_rdata};

    assign state_o = state_q;

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Pipeline memory stage: performs byte/word loads and stores through a
// byte-wide bus, stalls upstream while an access is outstanding, and owns
// the MEM/WB latch.
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   Wr_id_in            destination register (0 = no write)
//   Fmask_in, Flags_in  flag-write mask and ALU flags
//   MEMctrl             [0] RD [1] WR [2] IO [3] WORD [4] LDSEL
//   Result_in           ALU result / access address
//   Src1_in             store data
//   EOI_in, seqNPC_in   end of instruction, sequential next PC
//   bus                 memory bus, master side
//   mem_pipe_stall      hold EXE latch and all upstream stages
//   WB_*                MEM/WB latch outputs
//   paging_RQ           one-cycle pulse after a mapper-register write
//   dbg_state_o         bus sequencer state
// -----------------------------------------------------------------------------
module mem_stage
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  Wr_id_in,
    input  logic [7:0]  Fmask_in,
    input  logic [7:0]  Flags_in,
    input  logic [6:0]  MEMctrl,
    input  logic [15:0] Result_in,
    input  logic [15:0] Src1_in,
    input  logic        EOI_in,
    input  logic [15:0] seqNPC_in,
    mem_stage_if.master bus,
    output logic        mem_pipe_stall,
    output logic [15:0] WB_Result,
    output logic [4:0]  WB_Wr_id,
    output logic [7:0]  WB_Flags,
    output logic [7:0]  WB_Fmask,
    output logic        WB_EOI,
    output logic [15:0] WB_seqNPC,
    output logic        paging_RQ,
    output mem_state_e  dbg_state_o
);

    logic        rd_eff;
    logic        wr_eff;
    logic        io_sel;
    logic        word_sel;
    logic        mem_op;
    logic        final_ack;
    logic [15:0] load_data;
    logic [15:0] addr_hi;
    logic        map_hit;
    logic        unused_memctrl;

    logic [15:0] wb_result_q;
    logic [4:0]  wb_wr_id_q;
    logic [7:0]  wb_flags_q;
    logic [7:0]  wb_fmask_q;
    logic        wb_eoi_q;
    logic [15:0] wb_seqnpc_q;
    logic        paging_q;

    assign unused_memctrl = ^MEMctrl[6:5];

    // RD and WR together behave as a plain read.
    assign rd_eff   = MEMctrl[MC_RD];
    assign wr_eff   = MEMctrl[MC_WR] & ~MEMctrl[MC_RD];
    assign io_sel   = MEMctrl[MC_IO];
    assign word_sel = MEMctrl[MC_WORD];
    assign mem_op   = rd_eff | wr_eff;
    assign addr_hi  = Result_in + 16'd1;

    mem_bus_fsm u_bus_fsm (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .mem_op_i    (mem_op),
        .rd_i        (rd_eff),
        .wr_i        (wr_eff),
        .io_i        (io_sel),
        .word_i      (word_sel),
        .addr_lo_i   (Result_in),
        .addr_hi_i   (addr_hi),
        .wdata_i     (Src1_in),
        .bus         (bus),
        .final_ack_o (final_ack),
        .load_data_o (load_data),
        .state_o     (dbg_state_o)
    );

    assign mem_pipe_stall = mem_op & ~final_ack;

    // A word store touches Result_in and Result_in+1 (wrapping), so 0xFFFB
    // and 0xFFFF both reach the mapper window.
    assign map_hit = is_mapper(Result_in) |
                     (word_sel & ~io_sel & is_mapper(addr_hi));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wb_result_q <= 16'h0000;
            wb_wr_id_q  <= 5'd0;
            wb_flags_q  <= 8'h00;
            wb_fmask_q  <= 8'h00;
            wb_eoi_q    <= 1'b0;
            wb_seqnpc_q <= 16'h0000;
            paging_q    <= 1'b0;
        end else if (!mem_pipe_stall) begin
            wb_result_q <= MEMctrl[MC_LDSEL] ? load_data : Result_in;
            wb_wr_id_q  <= Wr_id_in;
            wb_flags_q  <= Flags_in;
            wb_fmask_q  <= Fmask_in;
            wb_eoi_q    <= EOI_in;
            wb_seqnpc_q <= seqNPC_in;
            // With no stall, a memory op here is completing its last byte.
            paging_q    <= mem_op & wr_eff & ~io_sel & map_hit;
        end else begin
            // Bubble: nothing architectural is written while stalled.
            wb_wr_id_q  <= 5'd0;
            wb_fmask_q  <= 8'h00;
            wb_eoi_q    <= 1'b0;
            paging_q    <= 1'b0;
        end
    end

    assign WB_Result = wb_result_q;
    assign WB_Wr_id  = wb_wr_id_q;
    assign WB_Flags  = wb_flags_q;
    assign WB_Fmask  = wb_fmask_q;
    assign WB_EOI    = wb_eoi_q;
    assign WB_seqNPC = wb_seqnpc_q;
    assign paging_RQ = paging_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: a directed vector table, hand-written
// sequences for back-to-back issue and mid-access reset, then random
// instructions checked against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_mem_stage;
    import cpu_pkg::*;

    localparam logic [6:0] C_RD    = 7'h01;
    localparam logic [6:0] C_WR    = 7'h02;
    localparam logic [6:0] C_IO    = 7'h04;
    localparam logic [6:0] C_WORD  = 7'h08;
    localparam logic [6:0] C_LDSEL = 7'h10;

    typedef struct {
        logic [4:0]  wr_id;
        logic [7:0]  fmask;
        logic [7:0]  flags;
        logic [6:0]  mc;
        logic [15:0] result;
        logic [15:0] src1;
        logic        eoi;
        logic [15:0] npc;
    } instr_t;

    typedef struct {
        instr_t      ins;
        int          lat;
        logic [15:0] exp_res;
        int          exp_stalls;
        logic        exp_pg;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic RST;
    int   cyc_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- DUT ----------------
    logic [4:0]  Wr_id_in;
    logic [7:0]  Fmask_in;
    logic [7:0]  Flags_in;
    logic [6:0]  MEMctrl;
    logic [15:0] Result_in;
    logic [15:0] Src1_in;
    logic        EOI_in;
    logic [15:0] seqNPC_in;
    logic        mem_pipe_stall;
    logic [15:0] WB_Result;
    logic [4:0]  WB_Wr_id;
    logic [7:0]  WB_Flags;
    logic [7:0]  WB_Fmask;
    logic        WB_EOI;
    logic [15:0] WB_seqNPC;
    logic        paging_RQ;
    mem_state_e  dbg_state;

    mem_stage_if bus();

    mem_stage dut (
        .CLK            (clk),
        .RST            (RST),
        .Wr_id_in       (Wr_id_in),
        .Fmask_in       (Fmask_in),
        .Flags_in       (Flags_in),
        .MEMctrl        (MEMctrl),
        .Result_in      (Result_in),
        .Src1_in        (Src1_in),
        .EOI_in         (EOI_in),
        .seqNPC_in      (seqNPC_in),
        .bus            (bus),
        .mem_pipe_stall (mem_pipe_stall),
        .WB_Result      (WB_Result),
        .WB_Wr_id       (WB_Wr_id),
        .WB_Flags       (WB_Flags),
        .WB_Fmask       (WB_Fmask),
        .WB_EOI         (WB_EOI),
        .WB_seqNPC      (WB_seqNPC),
        .paging_RQ      (paging_RQ),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0]  mem_img [0:65535];
    logic [7:0]  io_img  [0:255];
    // {io, rd, wr, addr[15:0], wdata[7:0]} per expected byte access
    logic [26:0] exp_q[$];
    int          n_cmp;
    int          n_fail;
    int          last_wb_cyc;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] wr_id, input logic [7:0] fmask,
                                  input logic [7:0] flags, input logic [6:0] mc,
                                  input logic [15:0] result, input logic [15:0] src1,
                                  input logic eoi, input logic [15:0] npc);
        instr_t i;
        i.wr_id = wr_id; i.fmask = fmask; i.flags = flags; i.mc = mc;
        i.result = result; i.src1 = src1; i.eoi = eoi; i.npc = npc;
        return i;
    endfunction

    task automatic add_vec(input instr_t ins, input int lat, input logic [15:0] res,
                           input int stalls, input logic pg);
        vec_t v;
        v.ins = ins; v.lat = lat; v.exp_res = res; v.exp_stalls = stalls; v.exp_pg = pg;
        vecs.push_back(v);
    endtask

    // Behavioural model: lists the byte accesses the instruction must make,
    // the value written back, the stall count for a slave that answers each
    // byte after 'lat' wait cycles, and whether a mapper write occurs.
    function automatic void model(input instr_t i, input int lat, output logic [15:0] res,
                                  output int stalls, output logic pg);
        logic rd, wr, io, word;
        int nb;
        logic [15:0] a;
        logic [15:0] load;
        logic [7:0]  b;
        logic [7:0]  wd;
        rd   = i.mc[0];
        wr   = i.mc[1] && !i.mc[0];
        io   = i.mc[2];
        word = i.mc[3];
        nb   = !(rd || wr) ? 0 : ((word && !io) ? 2 : 1);
        load = 16'h0000;
        pg   = 1'b0;
        for (int k = 0; k < nb; k++) begin
            a = i.result + 16'(k);
            b = io ? io_img[a[7:0]] : mem_img[a];
            if (rd) load = load | (16'(b) << (8 * k));
            wd = !wr ? 8'h00 : ((k == 0) ? i.src1[7:0] : i.src1[15:8]);
            exp_q.push_back({io, rd, wr, a, wd});
            if (wr && !io && a >= 16'hFFFC) pg = 1'b1;
        end
        res    = i.mc[4] ? load : i.result;
        stalls = nb * (lat + 1);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input instr_t i);
        Wr_id_in  = i.wr_id;
        Fmask_in  = i.fmask;
        Flags_in  = i.flags;
        MEMctrl   = i.mc;
        Result_in = i.result;
        Src1_in   = i.src1;
        EOI_in    = i.eoi;
        seqNPC_in = i.npc;
    endtask

    // Presents one instruction, plays the memory slave (ack after 'lat'
    // wait cycles per byte) and checks bus traffic, bubbles and the WB
    // update. Returns just after the WB-update edge.
    task automatic exec(input instr_t ins, input int lat, input logic [15:0] e_res,
                        input int e_stalls, input logic e_pg, input string tag);
        int   stalls;
        int   waitc;
        int   guard;
        bit   done;
        bit   acked;
        logic st;
        logic [26:0] obs;
        @(negedge clk);
        drive(ins);
        stalls = 0; waitc = 0; guard = 0; done = 0;
        while (!done) begin
            acked = 0;
            if (bus.mem_rd || bus.mem_wr) begin
                obs = {bus.mem_io, bus.mem_rd, bus.mem_wr, bus.mem_addr,
                       bus.mem_wr ? bus.mem_wdata : 8'h00};
                chk({tag, "_access_expected"}, 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk({tag, "_access"}, 32'(obs), 32'(exp_q[0]));
                if (waitc == lat) begin
                    acked = 1;
                    bus.mem_rdata = bus.mem_io ? io_img[bus.mem_addr[7:0]] : mem_img[bus.mem_addr];
                end else begin
                    waitc++;
                    bus.mem_rdata = 8'($urandom);
                end
            end
            bus.mem_ack = acked;
            #1;
            st = mem_pipe_stall;
            if (acked && exp_q.size() > 0) void'(exp_q.pop_front());
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (acked) waitc = 0;
            if (st) begin
                stalls++;
                chk({tag, "_bubble_wr_id"}, 32'(WB_Wr_id), 32'd0);
                chk({tag, "_bubble_fmask"}, 32'(WB_Fmask), 32'd0);
                chk({tag, "_bubble_eoi"},   32'(WB_EOI),   32'd0);
                chk({tag, "_paging_idle"},  32'(paging_RQ), 32'd0);
            end else begin
                done = 1;
                last_wb_cyc = cyc_cnt;
                chk({tag, "_wb_result"}, 32'(WB_Result), 32'(e_res));
                chk({tag, "_wb_wr_id"},  32'(WB_Wr_id),  32'(ins.wr_id));
                chk({tag, "_wb_flags"},  32'(WB_Flags),  32'(ins.flags));
                chk({tag, "_wb_fmask"},  32'(WB_Fmask),  32'(ins.fmask));
                chk({tag, "_wb_eoi"},    32'(WB_EOI),    32'(ins.eoi));
                chk({tag, "_wb_npc"},    32'(WB_seqNPC), 32'(ins.npc));
                chk({tag, "_paging"},    32'(paging_RQ), 32'(e_pg));
            end
            guard++;
            if (!done) begin
                if (guard >= 64) begin
                    chk({tag, "_timeout"}, 32'(guard), 32'(e_stalls + 1));
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(e_stalls));
        chk({tag, "_accesses_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        logic [15:0] m_res;
        int          m_stalls;
        logic        m_pg;
        int          wb_a;
        instr_t      ins;
        logic [6:0]  mc;
        logic [15:0] addr;

        for (int a = 0; a < 65536; a++) mem_img[a] = 8'($urandom);
        for (int a = 0; a < 256; a++) io_img[a] = 8'($urandom);
        mem_img[16'h0100] = 8'hA5;
        mem_img[16'h1000] = 8'h34;
        mem_img[16'h1001] = 8'h12;
        mem_img[16'hFFFD] = 8'h77;
        mem_img[16'hFFFF] = 8'h9A;
        mem_img[16'h0000] = 8'h56;
        io_img[8'h7E]     = 8'h3C;

        RST = 1'b0;
        drive(mk(5'd0, 8'h00, 8'h00, 7'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000));
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",     32'(dbg_state), 32'(ST_IDLE));
        chk("rst_mem_rd",    32'(bus.mem_rd), 32'd0);
        chk("rst_mem_wr",    32'(bus.mem_wr), 32'd0);
        chk("rst_mem_io",    32'(bus.mem_io), 32'd0);
        chk("rst_paging",    32'(paging_RQ), 32'd0);
        chk("rst_wb_result", 32'(WB_Result), 32'd0);
        chk("rst_wb_wr_id",  32'(WB_Wr_id), 32'd0);
        chk("rst_wb_npc",    32'(WB_seqNPC), 32'd0);
        @(negedge clk);
        RST = 1'b1;

        // Directed table
        add_vec(mk(5'd3, 8'hFF, 8'h81, 7'h00, 16'h1234, 16'h0000, 1'b1, 16'h0101), 0, 16'h1234, 0, 1'b0);
        add_vec(mk(5'd4, 8'h00, 8'h11, C_RD | C_LDSEL, 16'h0100, 16'h0000, 1'b1, 16'h0102), 2, 16'h00A5, 3, 1'b0);
        add_vec(mk(5'd0, 8'h00, 8'h22, C_WR | C_WORD, 16'hFFFF, 16'hBEEF, 1'b1, 16'h0103), 0, 16'hFFFF, 2, 1'b1);
        add_vec(mk(5'd5, 8'h0F, 8'h33, C_RD | C_IO | C_WORD | C_LDSEL, 16'h007E, 16'h0000, 1'b1, 16'h0104), 1, 16'h003C, 2, 1'b0);
        add_vec(mk(5'd6, 8'hF0, 8'h44, C_RD | C_WORD | C_LDSEL, 16'h1000, 16'h0000, 1'b0, 16'h0105), 1, 16'h1234, 4, 1'b0);
        add_vec(mk(5'd7, 8'h00, 8'h55, C_RD | C_WR | C_LDSEL, 16'hFFFD, 16'h1111, 1'b1, 16'h0106), 0, 16'h0077, 1, 1'b0);
        add_vec(mk(5'd0, 8'h00, 8'h66, C_WR, 16'hFFFC, 16'h00AB, 1'b1, 16'h0107), 0, 16'hFFFC, 1, 1'b1);
        add_vec(mk(5'd0, 8'h00, 8'h77, C_WR | C_IO, 16'hFFFC, 16'h00CD, 1'b1, 16'h0108), 0, 16'hFFFC, 1, 1'b0);
        add_vec(mk(5'd0, 8'h00, 8'h88, C_WR | C_WORD, 16'hFFFB, 16'h1357, 1'b1, 16'h0109), 1, 16'hFFFB, 4, 1'b1);
        add_vec(mk(5'd0, 8'h00, 8'h99, C_WR | C_WORD, 16'hFFFA, 16'h2468, 1'b1, 16'h010A), 0, 16'hFFFA, 2, 1'b0);
        add_vec(mk(5'd8, 8'h01, 8'hAA, C_RD | C_WORD | C_LDSEL, 16'hFFFF, 16'h0000, 1'b1, 16'h010B), 0, 16'h569A, 2, 1'b0);
        add_vec(mk(5'd9, 8'h02, 8'hBB, 7'h60, 16'hCAFE, 16'h0000, 1'b1, 16'h010C), 0, 16'hCAFE, 0, 1'b0);
        add_vec(mk(5'd10, 8'h03, 8'hCC, C_RD, 16'h0300, 16'h0000, 1'b0, 16'h010D), 2, 16'h0300, 3, 1'b0);

        foreach (vecs[v]) begin
            model(vecs[v].ins, vecs[v].lat, m_res, m_stalls, m_pg);
            exec(vecs[v].ins, vecs[v].lat, vecs[v].exp_res, vecs[v].exp_stalls,
                 vecs[v].exp_pg, $sformatf("vec%0d", v));
        end

        // Back-to-back: byte load followed by an ALU op
        ins = mk(5'd11, 8'h00, 8'h01, C_RD | C_LDSEL, 16'h0100, 16'h0000, 1'b1, 16'h0200);
        model(ins, 0, m_res, m_stalls, m_pg);
        exec(ins, 0, 16'h00A5, 1, 1'b0, "b2b_load");
        wb_a = last_wb_cyc;
        ins = mk(5'd12, 8'h00, 8'h02, 7'h00, 16'h4321, 16'h0000, 1'b1, 16'h0201);
        model(ins, 0, m_res, m_stalls, m_pg);
        exec(ins, 0, 16'h4321, 0, 1'b0, "b2b_alu");
        chk("b2b_wb_gap", 32'(last_wb_cyc - wb_a), 32'd1);

        // Reset while the high byte of a word read is outstanding
        @(negedge clk);
        drive(mk(5'd13, 8'hFF, 8'h03, C_RD | C_WORD | C_LDSEL, 16'h2000, 16'h0000, 1'b1, 16'h0300));
        @(posedge clk);
        #1;
        chk("rstmid_acc_lo", 32'(dbg_state), 32'(ST_ACC_LO));
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h11;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        chk("rstmid_acc_hi", 32'(dbg_state), 32'(ST_ACC_HI));
        chk("rstmid_rd_on",  32'(bus.mem_rd), 32'd1);
        @(negedge clk);
        RST = 1'b0;
        #1;
        chk("rstmid_mem_rd",    32'(bus.mem_rd), 32'd0);
        chk("rstmid_mem_wr",    32'(bus.mem_wr), 32'd0);
        chk("rstmid_mem_io",    32'(bus.mem_io), 32'd0);
        chk("rstmid_wb_wr_id",  32'(WB_Wr_id), 32'd0);
        chk("rstmid_wb_result", 32'(WB_Result), 32'd0);
        chk("rstmid_state",     32'(dbg_state), 32'(ST_IDLE));
        drive(mk(5'd0, 8'h00, 8'h00, 7'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000));
        @(negedge clk);
        RST = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_state_after", 32'(dbg_state), 32'(ST_IDLE));
        chk("rstmid_stall_after", 32'(mem_pipe_stall), 32'd0);

        // Random instructions against the model
        for (int n = 0; n < 150; n++) begin
            int lat;
            mc = 7'($urandom_range(0, 127));
            if (!mc[0]) mc[4] = 1'b0;
            addr = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                              : 16'($urandom);
            ins = mk(5'($urandom), 8'($urandom), 8'($urandom), mc, addr,
                     16'($urandom), 1'($urandom), 16'($urandom));
            lat = $urandom_range(0, 2);
            model(ins, lat, m_res, m_stalls, m_pg);
            exec(ins, lat, m_res, m_stalls, m_pg, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
